// File: rtl/factorial_pkg.sv
// -----------------------------------------------------------------------------
// factorial_pkg
// Shared definitions for the factorial engine:
//   - state_e       : FSM state encoding (IDLE, CALC, DONE)
//   - N_WIDTH_DEF   : default operand width
//   - R_WIDTH_DEF   : default result width
//   - SAT_DEF       : saturation value at the default result width
// -----------------------------------------------------------------------------
package factorial_pkg;

    localparam int N_WIDTH_DEF = 5;
    localparam int R_WIDTH_DEF = 32;

    localparam logic [R_WIDTH_DEF-1:0] SAT_DEF = {R_WIDTH_DEF{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : factorial_pkg

// File: rtl/factorial_mul_sat.sv
// -----------------------------------------------------------------------------
// factorial_mul_sat
// Combinational accumulator step: multiplies the running product by the
// current counter, detects overflow of the result width and saturates.
// Ports:
//   i_acc      [R_WIDTH]  running product
//   i_cnt      [N_WIDTH]  current multiplier
//   i_ovf      1          overflow already seen in this operation
//   o_next_acc [R_WIDTH]  next product (all-ones once overflow is seen)
//   o_ovf      1          sticky overflow flag for the next step
// -----------------------------------------------------------------------------
import factorial_pkg::*;

module factorial_mul_sat #(
    parameter int N_WIDTH = N_WIDTH_DEF,
    parameter int R_WIDTH = R_WIDTH_DEF
) (
    input  logic [R_WIDTH-1:0] i_acc,
    input  logic [N_WIDTH-1:0] i_cnt,
    input  logic               i_ovf,
    output logic [R_WIDTH-1:0] o_next_acc,
    output logic               o_ovf
);

    logic [2*R_WIDTH-1:0] w_prod;

    // Full double-width product so any carry into the upper half is visible.
    assign w_prod = {{R_WIDTH{1'b0}}, i_acc} * {{(2*R_WIDTH-N_WIDTH){1'b0}}, i_cnt};

    // Saturate when the product spills over or overflow was already sticky.
    always_comb begin
        o_next_acc = {R_WIDTH{1'b0}};
        o_ovf      = 1'b0;
        if (i_ovf || (w_prod[2*R_WIDTH-1:R_WIDTH] != {R_WIDTH{1'b0}})) begin
            o_next_acc = {R_WIDTH{1'b1}};
            o_ovf      = 1'b1;
        end else begin
            o_next_acc = w_prod[R_WIDTH-1:0];
            o_ovf      = 1'b0;
        end
    end

endmodule : factorial_mul_sat

// File: rtl/factorial_seq.sv
// -----------------------------------------------------------------------------
// factorial_seq
// Multi-cycle factorial engine, one multiply per clock. Operand n is taken
// over a valid/ready handshake in IDLE, the product is iterated in CALC from
// n downwards, and the (saturating) result is held in DONE until accepted.
// Ports:
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_valid   operand valid           o_ready   operand accepted (IDLE only)
//   i_n       operand n
//   o_valid   result valid (DONE)     i_ready   downstream accepts result
//   o_result  n! or all-ones on overflow
//   o_ovf     true n! exceeds the result width
//   o_busy    engine is iterating (CALC)
// -----------------------------------------------------------------------------
import factorial_pkg::*;

module factorial_seq #(
    parameter int N_WIDTH = N_WIDTH_DEF,
    parameter int R_WIDTH = R_WIDTH_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [N_WIDTH-1:0] i_n,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [R_WIDTH-1:0] o_result,
    output logic               o_ovf,
    output logic               o_busy
);

    state_e             r_state;
    state_e             w_state_next;
    logic [N_WIDTH-1:0] r_cnt;
    logic [R_WIDTH-1:0] r_acc;
    logic               r_ovf;
    logic [R_WIDTH-1:0] w_next_acc;
    logic               w_next_ovf;
    logic               w_cnt_gt1;

    assign w_cnt_gt1 = (r_cnt > N_WIDTH'(1));

    factorial_mul_sat #(
        .N_WIDTH (N_WIDTH),
        .R_WIDTH (R_WIDTH)
    ) u_mul_sat (
        .i_acc      (r_acc),
        .i_cnt      (r_cnt),
        .i_ovf      (r_ovf),
        .o_next_acc (w_next_acc),
        .o_ovf      (w_next_ovf)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_valid) begin
                    w_state_next = CALC;
                end else begin
                    w_state_next = IDLE;
                end
            end
            CALC: begin
                // cnt<=1 ends the loop; n=0 and n=1 leave acc at 1.
                if (w_cnt_gt1) begin
                    w_state_next = CALC;
                end else begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = DONE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Handshake/status outputs decoded from the state register only.
    always_comb begin
        o_ready = 1'b0;
        o_valid = 1'b0;
        o_busy  = 1'b0;
        case (r_state)
            IDLE:    o_ready = 1'b1;
            CALC:    o_busy  = 1'b1;
            DONE:    o_valid = 1'b1;
            default: o_ready = 1'b0;
        endcase
    end

    // Datapath: load on accept, iterate in CALC, hold otherwise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= {N_WIDTH{1'b0}};
            r_acc <= {R_WIDTH{1'b0}};
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_cnt <= i_n;
                        r_acc <= R_WIDTH'(1);
                        r_ovf <= 1'b0;
                    end
                end
                CALC: begin
                    if (w_cnt_gt1) begin
                        r_acc <= w_next_acc;
                        r_ovf <= w_next_ovf;
                        r_cnt <= r_cnt - N_WIDTH'(1);
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign o_result = r_acc;
    assign o_ovf    = r_ovf;

endmodule : factorial_seq

// File: tb/tb_factorial_seq.sv
// -----------------------------------------------------------------------------
// tb_factorial_seq
// Self-checking bench for factorial_seq: directed operands from the
// operation description plus randomized operands and stalls, checked against
// a plain-arithmetic factorial reference.
// -----------------------------------------------------------------------------
module tb_factorial_seq;

    localparam int NW = 5;
    localparam int RW = 32;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          out_ready;
    logic [NW-1:0] in_n;
    logic          out_valid;
    logic          in_ready;
    logic [RW-1:0] out_result;
    logic          out_ovf;
    logic          out_busy;

    int n_checks = 0;
    int n_errors = 0;

    factorial_seq #(
        .N_WIDTH (NW),
        .R_WIDTH (RW)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (in_valid),
        .o_ready  (out_ready),
        .i_n      (in_n),
        .o_valid  (out_valid),
        .i_ready  (in_ready),
        .o_result (out_result),
        .o_ovf    (out_ovf),
        .o_busy   (out_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact n! by plain arithmetic, saturated to the result width.
    function automatic logic [RW:0] ref_fact(input int n);
        longint unsigned p;
        bit              ov;
        p  = 64'd1;
        ov = 1'b0;
        for (int k = 2; k <= n; k++) begin
            p = p * longint'(k);
            if (p > 64'h0000_0000_FFFF_FFFF) begin
                ov = 1'b1;
                break;
            end
        end
        if (ov) return {1'b1, 32'hFFFF_FFFF};
        return {1'b0, p[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, ".ready"},  64'(out_ready),  64'd1);
        check_val({tag, ".valid"},  64'(out_valid),  64'd0);
        check_val({tag, ".busy"},   64'(out_busy),   64'd0);
        check_val({tag, ".result"}, 64'(out_result), 64'd0);
        check_val({tag, ".ovf"},    64'(out_ovf),    64'd0);
    endtask

    // One full operation: accept n, measure latency, stall the result for
    // 'stall' extra cycles (0 = i_ready already high), then hand it off.
    task automatic run_op(input int n, input int stall);
        logic [RW:0] exp;
        int          cycles;
        int          lat;
        exp = ref_fact(n);
        lat = (n < 1) ? 1 : n;
        cycles = 0;
        while (!out_ready && cycles < 100) begin
            tick();
            cycles++;
        end
        check_val("ready_before_accept", 64'(out_ready), 64'd1);
        in_valid = 1'b1;
        in_n     = NW'(n);
        in_ready = (stall == 0);
        tick();
        in_valid = 1'b0;
        check_val("busy_after_accept", 64'(out_busy), (lat > 0) ? 64'(out_busy === 1'b1 || n <= 1 ? 1 : 0) : 64'd0);
        cycles = 1;
        // Operand activity while CALC runs must be ignored.
        while (!out_valid && cycles < 100) begin
            in_valid = 1'($urandom_range(0, 1));
            in_n     = NW'($urandom);
            tick();
            if (!out_valid) cycles++;
        end
        in_valid = 1'b0;
        check_val($sformatf("latency_n%0d", n), 64'(cycles), 64'(lat));
        check_val($sformatf("result_n%0d", n), 64'(out_result), 64'(exp[RW-1:0]));
        check_val($sformatf("ovf_n%0d", n), 64'(out_ovf), 64'(exp[RW]));
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_n     = NW'($urandom);
            tick();
            check_val("stall_valid", 64'(out_valid), 64'd1);
            check_val("stall_result", 64'(out_result), 64'(exp[RW-1:0]));
            check_val("stall_ready", 64'(out_ready), 64'd0);
        end
        in_valid = 1'b0;
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        check_val("after_handoff_valid", 64'(out_valid), 64'd0);
        check_val("after_handoff_ready", 64'(out_ready), 64'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_n     = '0;
        in_ready = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();
        check_reset_outputs("post_reset");

        // Directed operands, including the overflow boundary.
        run_op(10, 0);
        run_op(0, 1);
        run_op(1, 0);
        run_op(12, 2);
        run_op(13, 0);
        run_op(31, 1);
        // Backpressure with operand noise; the next result is unaffected.
        run_op(5, 6);
        run_op(5, 0);

        // Reset in the middle of CALC discards the operation.
        in_valid = 1'b1;
        in_n     = NW'(10);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check_val("mid_calc_busy", 64'(out_busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        tick();
        rst_n = 1'b1;
        tick();
        run_op(3, 1);

        // Back-to-back: second operand offered on the first ready cycle.
        run_op(4, 0);
        run_op(6, 0);

        // Randomized operands and stalls.
        for (int i = 0; i < 25; i++) begin
            run_op(int'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_factorial_seq
